// File: rtl/apb_i2c_slave_if.sv
// apb_i2c_slave_if: APB bus bundle for the I2C target register block
//  master: drives PSEL, PENABLE, PWRITE, PADDR, PWDATA; sees PRDATA, PREADY, PIRQ
//  slave : sees the request fields; drives PRDATA, PREADY, PIRQ
interface apb_i2c_slave_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PIRQ;
    modport master(output PSEL, PENABLE, PWRITE, PADDR, PWDATA, input PRDATA, PREADY, PIRQ);
    modport slave(input PSEL, PENABLE, PWRITE, PADDR, PWDATA, output PRDATA, PREADY, PIRQ);
endinterface

// File: rtl/apb_i2c_slave.sv
// apb_i2c_slave: APB-attached 7-bit-address I2C target with RX/TX byte registers and maskable IRQ
//  PCLK, PRESETn   : APB clock, asynchronous active-low reset
//  apb             : APB slave bundle (PSEL/PENABLE/PWRITE/PADDR/PWDATA in, PRDATA/PREADY/PIRQ out)
//  scl_i, sda_i    : I2C line inputs (SCL is never stretched)
//  sda_o, sda_oen_o: open-drain SDA drive; sda_o is constant 0, sda_oen_o=0 pulls SDA low
//  Define I2C_SLV_GLITCH_FILTER_EN to add a 3-sample spike filter after the synchronisers.
module apb_i2c_slave #(
    parameter logic [6:0] DEFAULT_ADDR = 7'h50,
    parameter int         SYNC_STAGES  = 2
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    apb_i2c_slave_if.slave    apb,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_o,
    output logic              sda_oen_o
);
    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE} state_t;
    state_t state;
    logic [SYNC_STAGES-1:0] scl_s, sda_s;
    logic [1:0] raw, flt;
    logic scl_d, sda_d, fall_d;
    logic [7:0] adr, txr, rxr, im, sh, sr, ld;
    logic txv, rxf, busy, rw, stopf, ovr, txur, nackf, phase, ack;
    logic [2:0] cnt, sel;
    logic wr, rd_rxr, scl_rise, scl_fall, start, stop, unused;
    assign raw = {scl_s[SYNC_STAGES-1], sda_s[SYNC_STAGES-1]};
`ifdef I2C_SLV_GLITCH_FILTER_EN
    logic [1:0][1:0] fcnt;
    // A line value is accepted only after three consecutive samples disagree with the current one
    always_ff @(posedge PCLK or negedge PRESETn)
        if (!PRESETn) begin
            flt  <= 2'b11;
            fcnt <= '0;
        end else begin
            for (int i = 0; i < 2; i++)
                if (raw[i] == flt[i]) fcnt[i] <= 2'd0;
                else if (fcnt[i] == 2'd2) begin
                    flt[i]  <= raw[i];
                    fcnt[i] <= 2'd0;
                end else fcnt[i] <= fcnt[i] + 2'd1;
        end
`else
    assign flt = raw;
`endif
    assign scl_rise = flt[1] & ~scl_d;
    assign scl_fall = ~flt[1] & scl_d;
    assign start    = flt[1] & scl_d & sda_d & ~flt[0];
    assign stop     = flt[1] & scl_d & ~sda_d & flt[0];
    // Lines idle high, so history resets to 1; fall_d delays SDA updates one PCLK past SCL fall
    always_ff @(posedge PCLK or negedge PRESETn)
        if (!PRESETn) begin
            scl_s  <= '1;
            sda_s  <= '1;
            scl_d  <= 1'b1;
            sda_d  <= 1'b1;
            fall_d <= 1'b0;
        end else begin
            scl_s  <= {scl_s[SYNC_STAGES-2:0], scl_i};
            sda_s  <= {sda_s[SYNC_STAGES-2:0], sda_i};
            scl_d  <= flt[1];
            sda_d  <= flt[0];
            fall_d <= scl_fall;
        end
    assign sel        = apb.PADDR[4:2];
    assign wr         = apb.PSEL & apb.PENABLE & apb.PWRITE;
    assign rd_rxr     = apb.PSEL & apb.PENABLE & ~apb.PWRITE & (sel == 3'd2);
    assign sr         = {nackf, txur, ovr, stopf, rw, busy, ~txv, rxf};
    assign ld         = txv ? txr : 8'hFF;
    assign apb.PREADY = 1'b1;
    assign apb.PIRQ   = |(sr & im & 8'hF3);
    assign apb.PRDATA = {24'h0, sel == 3'd0 ? adr : sel == 3'd1 ? txr : sel == 3'd2 ? rxr :
                                sel == 3'd3 ? sr : sel == 3'd4 ? im : 8'h00};
    assign sda_o      = 1'b0;
    assign unused     = &{1'b0, apb.PADDR[7:5], apb.PADDR[1:0], apb.PWDATA[31:8]};
    // APB side effects come first so that flag sets from the bus engine below take priority
    always_ff @(posedge PCLK or negedge PRESETn)
        if (!PRESETn) begin
            state <= IDLE;
            adr <= {1'b0, DEFAULT_ADDR};
            {txr, rxr, im, sh} <= '0;
            {txv, rxf, busy, rw, stopf, ovr, txur, nackf, phase, ack} <= '0;
            cnt <= '0;
            sda_oen_o <= 1'b1;
        end else begin
            if (wr && sel == 3'd0) adr <= apb.PWDATA[7:0];
            if (wr && sel == 3'd1) begin
                txr <= apb.PWDATA[7:0];
                txv <= 1'b1;
            end
            if (wr && sel == 3'd3) begin
                stopf <= stopf & ~apb.PWDATA[4];
                ovr   <= ovr & ~apb.PWDATA[5];
                txur  <= txur & ~apb.PWDATA[6];
                nackf <= nackf & ~apb.PWDATA[7];
            end
            if (wr && sel == 3'd4) im <= apb.PWDATA[7:0];
            if (rd_rxr) rxf <= 1'b0;
            if (stop) begin
                state <= IDLE;
                sda_oen_o <= 1'b1;
                if (busy) stopf <= 1'b1;
                busy <= 1'b0;
            end else if (start) begin
                state <= ADDR;
                cnt <= '0;
                sda_oen_o <= 1'b1;
                busy <= 1'b0;
            end else case (state)
                ADDR: if (scl_rise) begin
                    sh  <= {sh[6:0], flt[0]};
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        if (adr[7] && sh[6:0] == adr[6:0]) begin
                            state <= ADDR_ACK;
                            rw    <= flt[0];
                            busy  <= 1'b1;
                            phase <= 1'b0;
                        end else state <= IGNORE;
                    end
                end
                // phase marks that the ACK clock has risen; the next fall ends the ACK bit
                ADDR_ACK: if (scl_rise) phase <= 1'b1;
                else if (fall_d) begin
                    if (!phase) sda_oen_o <= 1'b0;
                    else begin
                        cnt <= '0;
                        if (rw) begin
                            state <= RD_DATA;
                            sh <= ld;
                            sda_oen_o <= ld[7];
                            txv <= 1'b0;
                            if (!txv) txur <= 1'b1;
                        end else begin
                            state <= WR_DATA;
                            sda_oen_o <= 1'b1;
                        end
                    end
                end
                WR_DATA: if (scl_rise) begin
                    sh  <= {sh[6:0], flt[0]};
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        state <= WR_ACK;
                        phase <= 1'b0;
                        ack   <= ~rxf | rd_rxr;
                        if (~rxf | rd_rxr) begin
                            rxr <= {sh[6:0], flt[0]};
                            rxf <= 1'b1;
                        end else ovr <= 1'b1;
                    end
                end
                WR_ACK: if (scl_rise) phase <= 1'b1;
                else if (fall_d) begin
                    if (!phase) sda_oen_o <= ~ack;
                    else begin
                        sda_oen_o <= 1'b1;
                        cnt <= '0;
                        state <= WR_DATA;
                    end
                end
                RD_DATA: if (scl_rise) begin
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        state <= RD_ACK;
                        phase <= 1'b0;
                    end
                end else if (fall_d) begin
                    sda_oen_o <= sh[6];
                    sh <= {sh[6:0], 1'b0};
                end
                RD_ACK: if (scl_rise) begin
                    if (phase) phase <= 1'b1;
                    else if (flt[0]) begin
                        nackf <= 1'b1;
                        state <= IGNORE;
                        sda_oen_o <= 1'b1;
                    end else phase <= 1'b1;
                end else if (fall_d) begin
                    if (!phase) sda_oen_o <= 1'b1;
                    else begin
                        state <= RD_DATA;
                        cnt <= '0;
                        sh <= ld;
                        sda_oen_o <= ld[7];
                        txv <= 1'b0;
                        if (!txv) txur <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
endmodule

// File: tb/tb_apb_i2c_slave.sv
// tb_apb_i2c_slave: register vector table plus bit-banged I2C master scenarios for apb_i2c_slave
module tb_apb_i2c_slave;
    localparam int Q = 100;
    logic PCLK = 1'b0, PRESETn = 1'b0, scl = 1'b1, sda_m = 1'b1;
    logic sda_o, sda_oen_o, mon = 1'b0, drove = 1'b0;
    wire  sda_bus = sda_oen_o ? sda_m : (sda_m & sda_o);
    int n_chk = 0, n_fail = 0;
    apb_i2c_slave_if apb();
    apb_i2c_slave #(.DEFAULT_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .apb(apb), .scl_i(scl), .sda_i(sda_bus),
        .sda_o(sda_o), .sda_oen_o(sda_oen_o));
    always #5 PCLK = ~PCLK;
    always @(negedge PCLK) if (mon && !sda_oen_o) drove = 1'b1;

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        logic        irq;
        string       name;
    } vec_t;
    vec_t vt[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apb_rw(input logic wr, input logic [7:0] a, input logic [31:0] d, output logic [31:0] q);
        @(posedge PCLK); #1;
        apb.PSEL = 1'b1; apb.PWRITE = wr; apb.PADDR = a; apb.PWDATA = d; apb.PENABLE = 1'b0;
        @(posedge PCLK); #1;
        apb.PENABLE = 1'b1;
        #2 q = apb.PRDATA;
        @(posedge PCLK); #1;
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    endtask

    task automatic apb_wr(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] q;
        apb_rw(1'b1, a, d, q);
    endtask

    task automatic apb_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] q;
        apb_rw(1'b0, a, 32'h0, q);
        check(name, q, exp);
    endtask

    task automatic do_reset();
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = '0; apb.PWDATA = '0;
        scl = 1'b1; sda_m = 1'b1;
        PRESETn = 1'b0;
        #22 PRESETn = 1'b1;
        #20;
    endtask

    task automatic i2c_bit(input logic b, output logic r);
        sda_m = b; #Q;
        scl = 1'b1; #Q;
        r = sda_bus; #Q;
        scl = 1'b0; #Q;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; #Q;
        scl = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #Q;
        scl = 1'b1; #Q;
        sda_m = 1'b1; #Q;
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) i2c_bit(b[i], r);
        i2c_bit(1'b1, ack);
    endtask

    task automatic rd_byte(input logic nack, output logic [7:0] v);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(1'b1, r);
            v[i] = r;
        end
        i2c_bit(nack, r);
    endtask

    initial begin
        logic [31:0] q;
        logic ack, r;
        logic [7:0] v;
        vt[0]  = '{1'b0, 8'h00, 32'h0,   32'h50, 1'b0, "ADR reset"};
        vt[1]  = '{1'b0, 8'h04, 32'h0,   32'h00, 1'b0, "TXR reset"};
        vt[2]  = '{1'b0, 8'h08, 32'h0,   32'h00, 1'b0, "RXR reset"};
        vt[3]  = '{1'b0, 8'h0C, 32'h0,   32'h02, 1'b0, "SR reset"};
        vt[4]  = '{1'b0, 8'h10, 32'h0,   32'h00, 1'b0, "IM reset"};
        vt[5]  = '{1'b1, 8'h10, 32'h02,  32'h00, 1'b1, "IM TXE irq"};
        vt[6]  = '{1'b0, 8'h10, 32'h0,   32'h02, 1'b1, "IM readback"};
        vt[7]  = '{1'b1, 8'h10, 32'h0C,  32'h00, 1'b0, "IM busy/rw not irq"};
        vt[8]  = '{1'b1, 8'h00, 32'h1D5, 32'h00, 1'b0, "ADR write"};
        vt[9]  = '{1'b0, 8'h00, 32'h0,   32'hD5, 1'b0, "ADR readback"};
        vt[10] = '{1'b1, 8'h04, 32'hA5,  32'h00, 1'b0, "TXR write"};
        vt[11] = '{1'b0, 8'h04, 32'h0,   32'hA5, 1'b0, "TXR readback"};
        vt[12] = '{1'b0, 8'h0C, 32'h0,   32'h00, 1'b0, "SR TXE cleared"};
        vt[13] = '{1'b1, 8'h0C, 32'hFF,  32'h00, 1'b0, "SR W1C write"};
        vt[14] = '{1'b0, 8'h0C, 32'h0,   32'h00, 1'b0, "SR RO bits kept"};
        vt[15] = '{1'b0, 8'h14, 32'h0,   32'h00, 1'b0, "unused reg"};
        vt[16] = '{1'b1, 8'h10, 32'h00,  32'h00, 1'b0, "IM clear"};

        do_reset();
        check("reset sda_oen", {31'h0, sda_oen_o}, 32'h1);
        check("reset PIRQ", {31'h0, apb.PIRQ}, 32'h0);
        check("PREADY", {31'h0, apb.PREADY}, 32'h1);
        for (int i = 0; i < 17; i++) begin
            apb_rw(vt[i].wr, vt[i].addr, vt[i].wdata, q);
            if (!vt[i].wr) check(vt[i].name, q, vt[i].exp);
            check({vt[i].name, " irq"}, {31'h0, apb.PIRQ}, {31'h0, vt[i].irq});
        end

        // write of one byte, then STOP
        do_reset();
        apb_wr(8'h00, 32'hD0); apb_wr(8'h10, 32'h01);
        i2c_start();
        wr_byte(8'hA0, ack); check("t1 addr ack", {31'h0, ack}, 32'h0);
        wr_byte(8'h3C, ack); check("t1 data ack", {31'h0, ack}, 32'h0);
        i2c_stop();
        apb_chk("t1 SR", 8'h0C, 32'h13);
        check("t1 PIRQ", {31'h0, apb.PIRQ}, 32'h1);
        apb_chk("t1 RXR", 8'h08, 32'h3C);
        apb_chk("t1 SR after RXR read", 8'h0C, 32'h12);
        check("t1 PIRQ after read", {31'h0, apb.PIRQ}, 32'h0);

        // foreign address is never acknowledged
        do_reset();
        apb_wr(8'h00, 32'hD0);
        drove = 1'b0; mon = 1'b1;
        i2c_start();
        wr_byte(8'hA2, ack); check("t2 addr nack", {31'h0, ack}, 32'h1);
        apb_chk("t2 SR mid", 8'h0C, 32'h02);
        wr_byte(8'h55, ack); check("t2 data nack", {31'h0, ack}, 32'h1);
        i2c_stop();
        mon = 1'b0;
        check("t2 never drove", {31'h0, drove}, 32'h0);
        apb_chk("t2 SR", 8'h0C, 32'h02);

        // overrun on the second byte
        do_reset();
        apb_wr(8'h00, 32'hD0);
        i2c_start();
        wr_byte(8'hA0, ack); check("t3 addr ack", {31'h0, ack}, 32'h0);
        wr_byte(8'h11, ack); check("t3 0x11 ack", {31'h0, ack}, 32'h0);
        wr_byte(8'h22, ack); check("t3 0x22 nack", {31'h0, ack}, 32'h1);
        apb_chk("t3 SR ovr", 8'h0C, 32'h27);
        apb_wr(8'h0C, 32'h20);
        apb_chk("t3 SR ovr cleared", 8'h0C, 32'h07);
        apb_chk("t3 RXR", 8'h08, 32'h11);
        i2c_stop();
        apb_chk("t3 SR stop", 8'h0C, 32'h12);

        // read one byte, master NACKs
        do_reset();
        apb_wr(8'h00, 32'hD0); apb_wr(8'h04, 32'h5A);
        apb_chk("t4 SR txv", 8'h0C, 32'h00);
        i2c_start();
        wr_byte(8'hA1, ack); check("t4 addr ack", {31'h0, ack}, 32'h0);
        rd_byte(1'b1, v); check("t4 read byte", {24'h0, v}, 32'h5A);
        apb_chk("t4 SR nackf", 8'h0C, 32'h8E);
        drove = 1'b0; mon = 1'b1;
        wr_byte(8'h00, ack);
        mon = 1'b0;
        check("t4 ignore released", {31'h0, drove}, 32'h0);
        check("t4 ignore nack", {31'h0, ack}, 32'h1);
        i2c_stop();
        apb_chk("t4 SR stop", 8'h0C, 32'h9A);
        apb_chk("t4 TXR", 8'h04, 32'h5A);

        // underrun read, then repeated START into a write
        do_reset();
        apb_wr(8'h00, 32'hD0); apb_wr(8'h10, 32'h40);
        i2c_start();
        wr_byte(8'hA1, ack); check("t5 addr ack", {31'h0, ack}, 32'h0);
        rd_byte(1'b1, v); check("t5 read FF", {24'h0, v}, 32'hFF);
        apb_chk("t5 SR txur", 8'h0C, 32'hCE);
        check("t5 PIRQ", {31'h0, apb.PIRQ}, 32'h1);
        i2c_start();
        wr_byte(8'hA0, ack); check("t5 rs addr ack", {31'h0, ack}, 32'h0);
        wr_byte(8'h77, ack); check("t5 data ack", {31'h0, ack}, 32'h0);
        i2c_stop();
        apb_chk("t5 SR", 8'h0C, 32'hD3);
        apb_chk("t5 RXR", 8'h08, 32'h77);

        // reset while the target drives a read bit
        do_reset();
        apb_wr(8'h00, 32'hD0); apb_wr(8'h04, 32'h00);
        i2c_start();
        wr_byte(8'hA1, ack); check("t6 addr ack", {31'h0, ack}, 32'h0);
        for (int i = 0; i < 3; i++) i2c_bit(1'b1, r);
        check("t6 driving bit", {31'h0, sda_oen_o}, 32'h0);
        PRESETn = 1'b0;
        #1 check("t6 async release", {31'h0, sda_oen_o}, 32'h1);
        #20 PRESETn = 1'b1;
        apb_chk("t6 SR after reset", 8'h0C, 32'h02);
        apb_wr(8'h00, 32'hD0);
        i2c_start();
        wr_byte(8'hA0, ack); check("t6 addr ack after reset", {31'h0, ack}, 32'h0);
        i2c_stop();
        apb_chk("t6 SR stop", 8'h0C, 32'h12);

`ifdef I2C_SLV_GLITCH_FILTER_EN
        // a 2-cycle SDA spike while SCL is high must not look like START
        do_reset();
        apb_wr(8'h00, 32'hD0);
        sda_m = 1'b0;
        #20 sda_m = 1'b1;
        #Q scl = 1'b0;
        #Q;
        wr_byte(8'hA0, ack); check("glitch no start", {31'h0, ack}, 32'h1);
        i2c_stop();
        apb_chk("glitch SR", 8'h0C, 32'h02);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
